// File: rtl/alu_byte_seq_if.sv
// Request/response handshake bundle for alu_byte_seq.
// Both handshakes use the same rule: a transfer happens on a rising clock
// edge where valid and ready are both high. While valid is high and ready is
// low, the sender holds valid and the payload unchanged.
// W must equal 8*NBYTES of the alu_byte_seq instance it connects to.
interface alu_byte_seq_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic [3:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_cout;

    // Requester / response consumer side
    modport master (
        output req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_cout
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_cout
    );
endinterface

// File: rtl/alu_byte_seq.sv
// alu_byte_seq: issue stage that runs an NBYTES-wide operation through an
// external 8-bit ALU one byte per cycle, LSB first, chaining carry for the
// add opcodes (0110/0111) and assembling the full-width result.
// Optional build macro ALU_BYTE_SEQ_FLAGS_EN adds registered rsp_zero and
// rsp_neg outputs describing the held result.
// dbg_state exposes the FSM state (0=IDLE, 1=EXEC, 2=DONE).
module alu_byte_seq #(
    parameter int NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_byte_seq_if.slave    bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_y,
    output logic [1:0]       dbg_state
`ifdef ALU_BYTE_SEQ_FLAGS_EN
    ,
    output logic             rsp_zero,
    output logic             rsp_neg
`endif
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic            cin_q, cin_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    y_q, y_d;
    logic            cout_q, cout_d;

    logic            is_add;
    logic [8:0]      byte_sum;
    logic            byte_carry;

    assign is_add = (op_q == OP_ADD) || (op_q == OP_ADDC);

    // ALU drive: byte idx of latched operands; idx is 0 outside EXEC so
    // IDLE/DONE present byte 0. Carry only chains for add ops inside EXEC.
    always_comb begin
        alu_a   = a_q[idx_q*8 +: 8];
        alu_b   = b_q[idx_q*8 +: 8];
        alu_op  = op_q;
        alu_cin = 1'b0;
        if (state_q == ST_EXEC && is_add) begin
            if (idx_q == '0) begin
                alu_cin = (op_q == OP_ADDC) ? cin_q : 1'b0;
            end else begin
                alu_cin = carry_q;
                alu_op  = OP_ADDC;
            end
        end
    end

    // The ALU has no carry out, so recompute it from the issued byte inputs.
    always_comb begin
        byte_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        byte_carry = byte_sum[8];
    end

    // Next-state logic: accept in IDLE, step bytes in EXEC, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        y_d     = y_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    cin_d   = bus.req_cin;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    y_d     = '0;
                    cout_d  = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d[idx_q*8 +: 8] = alu_y;
                carry_d           = byte_carry;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = is_add ? byte_carry : 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ALU_BYTE_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    // Flags are captured together with the final byte so they track rsp_y.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (state_q == ST_IDLE && bus.req_valid) begin
            zero_d = 1'b0;
            neg_d  = 1'b0;
        end else if (state_q == ST_EXEC && idx_q == LAST_IDX) begin
            zero_d = (y_d == '0);
            neg_d  = y_d[W-1];
        end
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign rsp_zero = zero_q;
    assign rsp_neg  = neg_q;
`else
    // Flag outputs are not built in this configuration.
`endif

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_y     = y_q;
    assign bus.rsp_cout  = cout_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_byte_seq.sv
// Bench for alu_byte_seq (NBYTES=4) with a behavioural 8-bit ALU model.
module tb_alu_byte_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_cin;
    logic [3:0] alu_op;
    logic [1:0] dbg_state;
`ifdef ALU_BYTE_SEQ_FLAGS_EN
    logic       rsp_zero, rsp_neg;
`endif

    int checks   = 0;
    int failures = 0;

    alu_byte_seq_if #(.W(32)) bus ();

    alu_byte_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .dbg_state (dbg_state)
`ifdef ALU_BYTE_SEQ_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU model for the opcodes this bench exercises.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic [3:0] op);
        case (op)
            4'b0001: return a + 8'd1;
            4'b0110: return a + b;
            4'b0111: return a + b + {7'd0, cin};
            4'b1010: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_a, alu_b, alu_cin, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present a request from IDLE, wait for rsp_valid, check latency,
    // the issued opcode/carry per byte and req_ready low while busy.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        int n;
        int lat;
        logic [15:0] act_ops, exp_ops;
        logic [3:0]  act_cins, exp_cins;
        logic        rr_seen;
        logic        carry;
        logic        add_op;
        logic [8:0]  s;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", n, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; act_ops = '0; act_cins = '0; rr_seen = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            if (lat < 4) begin
                act_ops[lat*4 +: 4] = alu_op;
                act_cins[lat]       = alu_cin;
            end
            rr_seen = rr_seen | bus.req_ready;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
        add_op = (op == 4'b0110) || (op == 4'b0111);
        carry  = (op == 4'b0111) ? cin : 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_ops[i*4 +: 4] = (op == 4'b0110 && i > 0) ? 4'b0111 : op;
            exp_cins[i]       = add_op ? carry : 1'b0;
            s     = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]} + {8'd0, exp_cins[i]};
            carry = s[8];
        end
        chk("op_seq", {16'd0, act_ops}, {16'd0, exp_ops});
        chk("cin_seq", {28'd0, act_cins}, {28'd0, exp_cins});
        chk("req_ready_busy", {31'd0, rr_seen}, 32'd0);
    endtask

    // Complete the response handshake and confirm return to IDLE.
    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("idle_after_rsp", {30'd0, dbg_state}, 32'd0);
        chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_y;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0110, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0};
        vecs[1] = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{4'b1010, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h00F0_1200, 1'b0};
        vecs[3] = '{4'b0001, 32'h00FF_01FF, 32'h0000_0000, 1'b0, 32'h0100_0200, 1'b0};
        vecs[4] = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{4'b0110, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vecs[6] = '{4'b0110, 32'h80FF_0000, 32'h80FF_0000, 1'b0, 32'h01FE_0000, 1'b1};
        vecs[7] = '{4'b1010, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, 1'b0};
        vecs[8] = '{4'b0111, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};

        // Reset
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
        bus.req_cin = 1'b0; bus.req_op = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_y", bus.rsp_y, 32'd0);
        chk("rst_rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cin);
            chk($sformatf("rsp_y[%0d]", v), bus.rsp_y, vecs[v].exp_y);
            chk($sformatf("rsp_cout[%0d]", v), {31'd0, bus.rsp_cout}, {31'd0, vecs[v].exp_cout});
`ifdef ALU_BYTE_SEQ_FLAGS_EN
            chk($sformatf("rsp_zero[%0d]", v), {31'd0, rsp_zero},
                {31'd0, (vecs[v].exp_y == 32'd0)});
            chk($sformatf("rsp_neg[%0d]", v), {31'd0, rsp_neg}, {31'd0, vecs[v].exp_y[31]});
`endif
            release_rsp();
        end

        // Backpressure: hold rsp_ready low for 5 cycles in DONE
        issue(4'b0110, 32'h1234_5678, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_y", bus.rsp_y, 32'h2345_6789);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        release_rsp();
        // Second request accepted on the very next edge
        issue(4'b0111, 32'h0000_00FF, 32'h0000_0000, 1'b1);
        chk("bp_second_y", bus.rsp_y, 32'h0000_0100);
        chk("bp_second_cout", {31'd0, bus.rsp_cout}, 32'd0);
        release_rsp();

        // Reset during EXEC at byte index 2
        bus.req_op = 4'b0110; bus.req_a = 32'h1111_1111; bus.req_b = 32'h2222_2222;
        bus.req_cin = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_exec_state", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_state", {30'd0, dbg_state}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rsp_y", bus.rsp_y, 32'd0);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        issue(4'b0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        chk("post_abort_y", bus.rsp_y, 32'h0000_0000);
        chk("post_abort_cout", {31'd0, bus.rsp_cout}, 32'd0);
        release_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
